// File: rtl/seg7_pkg.sv
// Shared types and constants for the AHB seven-segment display slave.
// Holds the register map and the active-low hex segment table.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam logic [1:0] REG_DIGITS = 2'd0;
  localparam logic [1:0] REG_DP     = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam seg_t       SEG_BLANK  = 7'h7F;

  // Segment order {g,f,e,d,c,b,a}; a 0 lights the segment.
  function automatic seg_t hex2seg(input logic [3:0] h);
    seg_t s;
    case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational nibble to active-low seven-segment pattern.
// Thin wrapper around the package table.
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] i_nib,
  output seg_t       o_seg
);

  assign o_seg = hex2seg(i_nib);

endmodule

// File: rtl/ahb_seg7_display.sv
// AHB-Lite write-side slave driving a multiplexed 4-digit common-anode display.
// Optional SEG7_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module ahb_seg7_display
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  input  logic [2:0]  HSIZE,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic        HREADY,
  input  logic        HSEL,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [3:0]  an_n
);

  localparam int unsigned CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);
  localparam bit HAS_BLANK = (BLANK_CYCLES > 0);

  logic          r_wr_en;
  logic          r_rd_en;
  logic [1:0]    r_addr;
  logic [15:0]   r_digits;
  logic [3:0]    r_dp;
  logic          r_en;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [15:0]   r_snap_dig;
  logic [3:0]    r_snap_dp;
  logic [6:0]    r_seg_n;
  logic          r_dp_n;
  logic [3:0]    r_an_n;

  logic          w_sel;
  logic          w_wrap;
  logic          w_load;
  logic          w_blank;
  logic          w_lz;
  logic [3:0]    w_nib;
  seg_t          w_seg;
  logic          w_unused;

  assign w_unused = ^{HSIZE, HADDR[31:4], HADDR[1:0], HWDATA[31:16]};

  assign HREADYOUT = 1'b1;
  assign w_sel = HREADY && HSEL && (HTRANS != 2'b00);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_wr_en <= 1'b0;
      r_rd_en <= 1'b0;
      r_addr  <= 2'd0;
    end else if (w_sel) begin
      r_wr_en <= HWRITE;
      r_rd_en <= !HWRITE;
      r_addr  <= HADDR[3:2];
    end else begin
      r_wr_en <= 1'b0;
      r_rd_en <= 1'b0;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_digits <= 16'h0000;
      r_dp     <= 4'h0;
      r_en     <= 1'b0;
    end else if (r_wr_en) begin
      unique case (1'b1)
        r_addr == REG_DIGITS: r_digits <= HWDATA[15:0];
        r_addr == REG_DP:     r_dp     <= HWDATA[3:0];
        r_addr == REG_CTRL:   r_en     <= HWDATA[0];
        default: ;
      endcase
    end
  end

  always_comb begin
    HRDATA = 32'h0;
    if (r_rd_en) begin
      unique case (1'b1)
        r_addr == REG_DIGITS: HRDATA = {16'h0, r_digits};
        r_addr == REG_DP:     HRDATA = {28'h0, r_dp};
        r_addr == REG_CTRL:   HRDATA = {31'h0, r_en};
        default:              HRDATA = 32'h0;
      endcase
    end
  end

  assign w_wrap = r_en && (r_cnt == LAST);
  // Snapshot at slot start so a mid-slot write never tears the lit digit.
  assign w_load = !r_en || w_wrap;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_cnt      <= '0;
      r_idx      <= 2'd0;
      r_snap_dig <= 16'h0000;
      r_snap_dp  <= 4'h0;
    end else begin
      if (!r_en) begin
        r_cnt <= '0;
        r_idx <= 2'd0;
      end else if (w_wrap) begin
        r_cnt <= '0;
        r_idx <= r_idx + 2'd1;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_load) begin
        r_snap_dig <= r_digits;
        r_snap_dp  <= r_dp;
      end
    end
  end

  assign w_blank = HAS_BLANK && (32'(r_cnt) < BLANK_CYCLES);
  assign w_nib   = r_snap_dig[{r_idx, 2'b00} +: 4];

  seg7_decoder u_dec (
    .i_nib (w_nib),
    .o_seg (w_seg)
  );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  always_comb begin
    w_lz = 1'b0;
    unique case (r_idx)
      2'd3: w_lz = (r_snap_dig[15:12] == 4'h0);
      2'd2: w_lz = (r_snap_dig[15:8] == 8'h00);
      2'd1: w_lz = (r_snap_dig[15:4] == 12'h000);
      default: w_lz = 1'b0;
    endcase
  end
`else
  assign w_lz = 1'b0;
`endif

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_an_n  <= 4'hF;
      r_seg_n <= SEG_BLANK;
      r_dp_n  <= 1'b1;
    end else if (!r_en || w_blank) begin
      r_an_n  <= 4'hF;
      r_seg_n <= SEG_BLANK;
      r_dp_n  <= 1'b1;
    end else begin
      r_an_n  <= ~(4'b0001 << r_idx);
      r_seg_n <= w_lz ? SEG_BLANK : w_seg;
      r_dp_n  <= ~r_snap_dp[r_idx];
    end
  end

  assign an_n  = r_an_n;
  assign seg_n = r_seg_n;
  assign dp_n  = r_dp_n;

endmodule

// File: tb/tb_ahb_seg7_display.sv
// Directed bench for ahb_seg7_display with SCAN_DIV=8, BLANK_CYCLES=2.
// Define SEG7_LEADING_ZERO_BLANK_EN to also cover leading-zero blanking.
module tb_ahb_seg7_display;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic        HREADY;
  logic        HSEL;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;

  int n_checks = 0;
  int n_errs   = 0;

  logic [6:0] seg_tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  ahb_seg7_display #(
    .SCAN_DIV     (8),
    .BLANK_CYCLES (2)
  ) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .HADDR     (HADDR),
    .HWDATA    (HWDATA),
    .HSIZE     (HSIZE),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HREADY    (HREADY),
    .HSEL      (HSEL),
    .HRDATA    (HRDATA),
    .HREADYOUT (HREADYOUT),
    .seg_n     (seg_n),
    .dp_n      (dp_n),
    .an_n      (an_n)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
  endtask

  task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
    @(posedge HCLK); #1;
    bus_idle();
    HWDATA = d;
    @(posedge HCLK); #1;
  endtask

  task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
    @(posedge HCLK); #1;
    bus_idle();
    d = HRDATA;
  endtask

  task automatic wr_rd(input logic [31:0] wa, input logic [31:0] wd,
                       input logic [31:0] ra, output logic [31:0] d);
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = wa;
    @(posedge HCLK); #1;
    HWDATA = wd; HWRITE = 1'b0; HADDR = ra;
    @(posedge HCLK); #1;
    bus_idle();
    d = HRDATA;
  endtask

  function automatic logic lz_blank(input logic [15:0] dg, input int idx);
    logic r;
    r = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (idx == 3) r = (dg[15:12] == 4'h0);
    if (idx == 2) r = (dg[15:8] == 8'h00);
    if (idx == 1) r = (dg[15:4] == 12'h000);
`endif
    return r;
  endfunction

  // Must be entered right after the enabling write returns.
  task automatic run_scan(input int n, input logic [15:0] dg,
                          input logic [3:0] dp);
    int c;
    int idx;
    logic [6:0] es;
    logic [3:0] ea;
    for (int k = 0; k < n; k++) begin
      @(posedge HCLK);
      @(negedge HCLK);
      c   = k % 8;
      idx = (k / 8) % 4;
      if (c < 2) begin
        check($sformatf("blank_an k%0d", k), {28'h0, an_n}, 32'hF);
      end else begin
        es = lz_blank(dg, idx) ? 7'h7F : seg_tab[dg[idx*4 +: 4]];
        ea = ~(4'b0001 << idx);
        check($sformatf("lit k%0d", k), {20'h0, dp_n, an_n, seg_n},
              {20'h0, ~dp[idx], ea, es});
      end
    end
  endtask

  logic [31:0] rd;
  logic [3:0]  seen;

  initial begin
    HRESET = 1'b1;
    HADDR  = 32'h0;
    HWDATA = 32'h0;
    HSIZE  = 3'b010;
    HREADY = 1'b1;
    bus_idle();
    repeat (3) @(posedge HCLK);
    #1;
    check("rst_an", {28'h0, an_n}, 32'hF);
    check("rst_seg", {25'h0, seg_n}, 32'h7F);
    check("rst_dp", {31'h0, dp_n}, 32'h1);
    check("rst_hrdata", HRDATA, 32'h0);
    check("hreadyout", {31'h0, HREADYOUT}, 32'h1);
    HRESET = 1'b0;

    seen = 4'hF;
    for (int i = 0; i < 1000; i++) begin
      @(negedge HCLK);
      if (an_n != 4'hF) seen = an_n;
    end
    check("idle_an", {28'h0, seen}, 32'hF);
    check("idle_seg", {25'h0, seg_n}, 32'h7F);

    ahb_write(32'h0, 32'h0000_1234);
    ahb_write(32'h8, 32'h1);
    run_scan(32, 16'h1234, 4'h0);

    ahb_write(32'h8, 32'h0);
    wr_rd(32'h4, 32'h4, 32'h4, rd);
    check("dp_raw", rd, 32'h4);
    ahb_write(32'h8, 32'h1);
    run_scan(32, 16'h1234, 4'b0100);

    ahb_write(32'hC, 32'hFFFF_FFFF);
    ahb_read(32'h0, rd);
    check("rsv_digits", rd, 32'h1234);
    ahb_read(32'h4, rd);
    check("rsv_dp", rd, 32'h4);
    ahb_read(32'h8, rd);
    check("rsv_ctrl", rd, 32'h1);
    ahb_read(32'hC, rd);
    check("rsv_read", rd, 32'h0);

    ahb_write(32'h8, 32'h0);
    ahb_write(32'h8, 32'h1);
    repeat (19) @(posedge HCLK);
    @(negedge HCLK);
    check("pre_rst_an", {28'h0, an_n}, 32'hB);
    @(posedge HCLK); #1;
    HRESET = 1'b1;
    @(posedge HCLK); #1;
    check("mid_rst_an", {28'h0, an_n}, 32'hF);
    check("mid_rst_seg", {25'h0, seg_n}, 32'h7F);
    HRESET = 1'b0;
    ahb_read(32'h0, rd);
    check("mid_rst_digits", rd, 32'h0);
    ahb_read(32'h8, rd);
    check("mid_rst_ctrl", rd, 32'h0);
    ahb_read(32'h4, rd);
    check("mid_rst_dp", rd, 32'h0);

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    ahb_write(32'h0, 32'h0000_0050);
    ahb_write(32'h4, 32'h8);
    ahb_write(32'h8, 32'h1);
    run_scan(32, 16'h0050, 4'h8);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
